// File: rtl/axil_ram_slave.sv
// AXI-lite slave backed by a word-addressed on-chip RAM; decode misses answer SLVERR.
// Optional byte-lane write enables are compiled in with `define AXIL_RAM_WSTRB_EN.
module axil_ram_slave #(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter int unsigned           DATA_WIDTH = 32,
    parameter int unsigned           MEM_WORDS  = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_WIDTH-1:0]   s_axil_awaddr,
    input  logic                    s_axil_awvalid,
    output logic                    s_axil_awready,
    input  logic [DATA_WIDTH-1:0]   s_axil_wdata,
    input  logic [DATA_WIDTH/8-1:0] s_axil_wstrb,
    input  logic                    s_axil_wvalid,
    output logic                    s_axil_wready,
    output logic [1:0]              s_axil_bresp,
    output logic                    s_axil_bvalid,
    input  logic                    s_axil_bready,
    input  logic [ADDR_WIDTH-1:0]   s_axil_araddr,
    input  logic                    s_axil_arvalid,
    output logic                    s_axil_arready,
    output logic [DATA_WIDTH-1:0]   s_axil_rdata,
    output logic [1:0]              s_axil_rresp,
    output logic                    s_axil_rvalid,
    input  logic                    s_axil_rready
);
    localparam int unsigned IdxW  = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam int unsigned StrbW = DATA_WIDTH / 8;
    localparam logic [1:0]  RespOkay   = 2'b00;
    localparam logic [1:0]  RespSlvErr = 2'b10;

    typedef enum logic [1:0] {WIdle, WHaveAw, WHaveW, WResp} w_state_e;
    typedef enum logic {RIdle, RResp} r_state_e;

    logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

    w_state_e              w_state_q, w_state_d;
    logic [ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [StrbW-1:0]      wstrb_q, wstrb_d;
    logic [1:0]            bresp_q, bresp_d;
    logic                  aw_hs, w_hs, commit;
    logic [ADDR_WIDTH-1:0] commit_addr;
    logic [DATA_WIDTH-1:0] commit_data;
    logic [StrbW-1:0]      commit_strb;
    logic [ADDR_WIDTH:0]   w_diff, r_diff;
    logic                  w_hit, r_hit;
    logic [IdxW-1:0]       w_idx, r_idx;

    r_state_e              r_state_q, r_state_d;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [1:0]            rresp_q;
    logic                  ar_hs;

    // Outputs are gated by rst so they read as idle during the whole reset cycle.
    assign s_axil_awready = !rst && (w_state_q == WIdle || w_state_q == WHaveW);
    assign s_axil_wready  = !rst && (w_state_q == WIdle || w_state_q == WHaveAw);
    assign s_axil_bvalid  = !rst && (w_state_q == WResp);
    assign s_axil_bresp   = rst ? RespOkay : bresp_q;
    assign s_axil_arready = !rst && (r_state_q == RIdle);
    assign s_axil_rvalid  = !rst && (r_state_q == RResp);
    assign s_axil_rdata   = rst ? '0 : rdata_q;
    assign s_axil_rresp   = rst ? RespOkay : rresp_q;

    assign aw_hs = s_axil_awvalid && s_axil_awready;
    assign w_hs  = s_axil_wvalid && s_axil_wready;
    assign ar_hs = s_axil_arvalid && s_axil_arready;

    // Extra MSB of the difference is the borrow: set when the address is below BASE_ADDR.
    always_comb begin
        w_diff = {1'b0, commit_addr} - {1'b0, BASE_ADDR};
        w_hit  = !w_diff[ADDR_WIDTH] && ((w_diff >> 2) < (ADDR_WIDTH + 1)'(MEM_WORDS));
        w_idx  = IdxW'(w_diff >> 2);
        r_diff = {1'b0, s_axil_araddr} - {1'b0, BASE_ADDR};
        r_hit  = !r_diff[ADDR_WIDTH] && ((r_diff >> 2) < (ADDR_WIDTH + 1)'(MEM_WORDS));
        r_idx  = IdxW'(r_diff >> 2);
    end

    always_comb begin
        w_state_d   = w_state_q;
        aw_addr_d   = aw_addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        bresp_d     = bresp_q;
        commit      = 1'b0;
        commit_addr = s_axil_awaddr;
        commit_data = s_axil_wdata;
        commit_strb = s_axil_wstrb;
        unique case (w_state_q)
            WIdle: begin
                if (aw_hs && w_hs) begin
                    commit    = 1'b1;
                    w_state_d = WResp;
                end else if (aw_hs) begin
                    aw_addr_d = s_axil_awaddr;
                    w_state_d = WHaveAw;
                end else if (w_hs) begin
                    wdata_d   = s_axil_wdata;
                    wstrb_d   = s_axil_wstrb;
                    w_state_d = WHaveW;
                end
            end
            WHaveAw: begin
                commit_addr = aw_addr_q;
                if (w_hs) begin
                    commit    = 1'b1;
                    w_state_d = WResp;
                end
            end
            WHaveW: begin
                commit_data = wdata_q;
                commit_strb = wstrb_q;
                if (aw_hs) begin
                    commit    = 1'b1;
                    w_state_d = WResp;
                end
            end
            WResp: begin
                if (s_axil_bready) w_state_d = WIdle;
            end
            default: w_state_d = WIdle;
        endcase
        if (commit) bresp_d = w_hit ? RespOkay : RespSlvErr;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w_state_q <= WIdle;
            aw_addr_q <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bresp_q   <= RespOkay;
        end else begin
            w_state_q <= w_state_d;
            aw_addr_q <= aw_addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            bresp_q   <= bresp_d;
        end
    end

`ifdef AXIL_RAM_WSTRB_EN
    always_ff @(posedge clk) begin
        if (commit && w_hit) begin
            for (int k = 0; k < StrbW; k++) begin
                if (commit_strb[k]) mem[w_idx][8*k +: 8] <= commit_data[8*k +: 8];
            end
        end
    end
`else
    logic unused_strb;
    assign unused_strb = ^commit_strb;

    always_ff @(posedge clk) begin
        if (commit && w_hit) mem[w_idx] <= commit_data;
    end
`endif

    always_comb begin
        r_state_d = r_state_q;
        unique case (r_state_q)
            RIdle:   if (ar_hs) r_state_d = RResp;
            RResp:   if (s_axil_rready) r_state_d = RIdle;
            default: r_state_d = RIdle;
        endcase
    end

    // Reading mem with a non-blocking update gives read-before-write on a same-edge collision.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= RIdle;
            rdata_q   <= '0;
            rresp_q   <= RespOkay;
        end else begin
            r_state_q <= r_state_d;
            if (ar_hs) begin
                rdata_q <= r_hit ? mem[r_idx] : '0;
                rresp_q <= r_hit ? RespOkay : RespSlvErr;
            end
        end
    end
endmodule
